// File: rtl/cl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cl_pkg
//  Description : Shared definitions for the 2-bit-select logic cell (cl)
//                family: select encodings, checker state encoding, vector
//                index width and the golden cell function.
//  Revision    : 1.0 - initial release
// ============================================================================
package cl_pkg;

    // Select encodings applied to the cell
    localparam logic [1:0] CL_AND = 2'b00;
    localparam logic [1:0] CL_OR  = 2'b01;
    localparam logic [1:0] CL_XOR = 2'b10;
    localparam logic [1:0] CL_NOT = 2'b11;

    // One stimulus vector is {s, a, b}
    localparam int CL_VEC_W = 4;

    // Checker state encoding
    localparam int         CL_STATE_W = 2;
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] RUN        = 2'd1;
    localparam logic [1:0] DONE       = 2'd2;

    // Golden cell behaviour
    function automatic logic cl_golden_f(input logic [1:0] sel, input logic op_a, input logic op_b);
        logic r;
        case (sel)
            CL_AND:  r = op_a & op_b;
            CL_OR:   r = op_a | op_b;
            CL_XOR:  r = op_a ^ op_b;
            default: r = ~op_a;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cl_golden.sv
`default_nettype none
// ============================================================================
//  Module      : cl_golden
//  Description : Purely combinational reference model of the cl cell.
//                Shared by all cl-family checkers.
//  Revision    : 1.0 - initial release
// ============================================================================
module cl_golden
    import cl_pkg::*;
(
    input  logic [1:0] s,
    input  logic       a,
    input  logic       b,
    output logic       exp
);

    // Expected cell output for the applied vector
    always_comb begin
        exp = cl_golden_f(s, a, b);
    end

endmodule
`default_nettype wire

// File: rtl/cl_resp_checker.sv
`default_nettype none
// ============================================================================
//  Module      : cl_resp_checker
//  Description : Response checker for the cl cell. Every accepted beat
//                {s,a,b,dut_out} is compared with the golden function;
//                saturating pass/fail counters, a per-round coverage mask,
//                the round count and the first failing vector are kept.
//                Optional macro CL_RESP_CHECKER_STOP_ON_FAIL_EN: the first
//                mismatch ends the run and raises halted_on_fail.
//  Revision    : 1.0 - initial release
// ============================================================================
module cl_resp_checker
    import cl_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int ROUNDS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vld,
    output logic             rdy,
    input  logic [1:0]       s,
    input  logic             a,
    input  logic             b,
    input  logic             dut_out,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [15:0]      cov_mask,
    output logic [7:0]       round_cnt,
    output logic [3:0]       first_fail,
    output logic             first_fail_vld,
    output logic             done,
    output logic             busy
`ifdef CL_RESP_CHECKER_STOP_ON_FAIL_EN
    ,
    output logic             halted_on_fail
`endif
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [7:0]       c_rounds  = 8'(ROUNDS);

    logic [CL_STATE_W-1:0] r_state;
    logic                  r_rdy;
    logic                  r_busy;
    logic                  r_done;
    logic [CNT_W-1:0]      r_pass;
    logic [CNT_W-1:0]      r_fail;
    logic [15:0]           r_cov;
    logic [7:0]            r_round;
    logic [CL_VEC_W-1:0]   r_ff;
    logic                  r_ffv;
`ifdef CL_RESP_CHECKER_STOP_ON_FAIL_EN
    logic                  r_halt;
`endif

    logic                  w_exp;
    logic                  w_xfer;
    logic                  w_match;
    logic [CL_VEC_W-1:0]   w_idx;
    logic [15:0]           w_cov_nxt;
    logic                  w_full;

    cl_golden u_golden (
        .s   (s),
        .a   (a),
        .b   (b),
        .exp (w_exp)
    );

    // Beat acceptance, comparison and coverage look-ahead. An X/Z on the
    // cell output makes w_match unknown, which falls into the mismatch
    // branch of the update below in simulation.
    always_comb begin
        w_xfer    = vld && (r_state == RUN) && !start;
        w_match   = (dut_out == w_exp);
        w_idx     = {s, a, b};
        w_cov_nxt = r_cov | (16'd1 << w_idx);
        w_full    = &w_cov_nxt;
    end

    // Control FSM and statistics; the bit set, full detect and clear of a
    // round all resolve on the edge of the completing beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rdy   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= '0;
            r_fail  <= '0;
            r_cov   <= '0;
            r_round <= '0;
            r_ff    <= '0;
            r_ffv   <= 1'b0;
`ifdef CL_RESP_CHECKER_STOP_ON_FAIL_EN
            r_halt  <= 1'b0;
`endif
        end else if (start) begin
            r_state <= RUN;
            r_rdy   <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= '0;
            r_fail  <= '0;
            r_cov   <= '0;
            r_round <= '0;
            r_ff    <= '0;
            r_ffv   <= 1'b0;
`ifdef CL_RESP_CHECKER_STOP_ON_FAIL_EN
            r_halt  <= 1'b0;
`endif
        end else if (w_xfer) begin
            if (w_match) begin
                if (r_pass != c_cnt_max) r_pass <= r_pass + 1'b1;
            end else begin
                if (r_fail != c_cnt_max) r_fail <= r_fail + 1'b1;
                if (!r_ffv) begin
                    r_ff  <= w_idx;
                    r_ffv <= 1'b1;
                end
`ifdef CL_RESP_CHECKER_STOP_ON_FAIL_EN
                r_state <= DONE;
                r_rdy   <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_halt  <= 1'b1;
`endif
            end
            if (w_full) begin
                r_cov   <= '0;
                r_round <= r_round + 8'd1;
                if (r_round + 8'd1 == c_rounds) begin
                    r_state <= DONE;
                    r_rdy   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
            end else begin
                r_cov <= w_cov_nxt;
            end
        end
    end

    assign rdy            = r_rdy;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass_cnt       = r_pass;
    assign fail_cnt       = r_fail;
    assign cov_mask       = r_cov;
    assign round_cnt      = r_round;
    assign first_fail     = r_ff;
    assign first_fail_vld = r_ffv;
`ifdef CL_RESP_CHECKER_STOP_ON_FAIL_EN
    assign halted_on_fail = r_halt;
`endif

endmodule
`default_nettype wire
